fetch_queue: RTL and testbench

Dual-word instruction fetch front end that drives both address ports of the 32-entry, two-read-port instruction memory. Each cycle it issues word addresses PC and PC+1, captures both returned instructions into a small in-order queue, and presents them one per cycle to the decode stage through a valid/ready handshake. It sits between the instruction memory and decode. A redirect input from branch/jump resolution flushes the queue and reloads the PC.

---
 rtl/fetch_queue.sv | 98 +++++++++
 tb/tb_fetch_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Dual-word instruction fetch front end.
// Every cycle it presents PC and PC+1 to the two read ports of the instruction
// memory. When the queue has room for two entries, both returned words are
// captured into a small in-order queue. The queue hands entries to decode one
// per cycle over a valid/ready handshake. A redirect flushes the queue and
// reloads the PC.
module fetch_queue #(
   parameter int         DEPTH    = 4,
   parameter logic [4:0] RESET_PC = 5'h00
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fetch_en,
   input  logic                     redirect,
   input  logic [4:0]               redirect_pc,
   output logic [4:0]               dir,
   output logic [4:0]               dir2,
   input  logic [31:0]              ins,
   input  logic [31:0]              ins2,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_ins,
   output logic [4:0]               out_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [4:0]    pc;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] wr_ptr_p1;
   logic [PW-1:0] wr_ptr_p2;
   logic [PW-1:0] rd_ptr_p1;
   logic          push;
   logic          pop;

   logic [4:0]    pc_mem  [DEPTH];
   logic [31:0]   ins_mem [DEPTH];

   // DEPTH need not be a power of two, so the pointers wrap explicitly.
   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
      int s;
      s = int'(p) + n;
      if (s >= DEPTH) s = s - DEPTH;
      return PW'(s);
   endfunction

   assign wr_ptr_p1 = ptr_add(wr_ptr, 1);
   assign wr_ptr_p2 = ptr_add(wr_ptr, 2);
   assign rd_ptr_p1 = ptr_add(rd_ptr, 1);

   assign dir  = pc;
   assign dir2 = pc + 5'd1;

   // A push needs two free slots at cycle start.
   // A pop in the same cycle does not free a slot early.
   assign push = fetch_en & ~redirect & (count <= CW'(DEPTH - 2));
   assign pop  = out_valid & out_ready;

   assign out_valid = (count != '0);
   assign out_ins   = out_valid ? ins_mem[rd_ptr] : 32'd0;
   assign out_pc    = out_valid ? pc_mem[rd_ptr]  : 5'd0;

   // Queue storage; empty entries are masked at the output, so no reset needed.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]     <= pc;
         ins_mem[wr_ptr]    <= ins;
         pc_mem[wr_ptr_p1]  <= pc + 5'd1;
         ins_mem[wr_ptr_p1] <= ins2;
      end
   end

   // PC, pointers and occupancy; redirect overrides both push and pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc     <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         pc     <= redirect_pc;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            pc     <= pc + 5'd2;
            wr_ptr <= wr_ptr_p2;
         end
         if (pop) rd_ptr <= rd_ptr_p1;
         count <= count + (push ? CW'(2) : CW'(0)) - (pop ? CW'(1) : CW'(0));
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. The reference model is a plain queue of
// {pc, ins} records, driven by the push/pop/redirect rules.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  pc;
      logic [31:0] ins;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_en = 1'b1;
   logic        redirect = 1'b0;
   logic [4:0]  redirect_pc = 5'd0;
   logic [4:0]  dir, dir2;
   logic [31:0] ins, ins2;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_ins;
   logic [4:0]  out_pc;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   entry_t     mq[$];
   logic [4:0] m_pc = 5'd0;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(5'h00)) dut (
      .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect(redirect),
      .redirect_pc(redirect_pc), .dir(dir), .dir2(dir2), .ins(ins), .ins2(ins2),
      .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
      .out_pc(out_pc), .count(count)
   );

   always #5 clk = ~clk;

   // Instruction memory: word k holds 0x1000_0000 + k.
   assign ins  = 32'h1000_0000 + {27'd0, dir};
   assign ins2 = 32'h1000_0000 + {27'd0, dir2};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model updated on each edge from the inputs at cycle start.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_pc = 5'd0;
      end else if (redirect) begin
         mq.delete();
         m_pc = redirect_pc;
      end else begin
         bit do_push, do_pop;
         do_push = fetch_en && (mq.size() <= DEPTH - 2);
         do_pop  = (mq.size() != 0) && out_ready;
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back({m_pc, 32'h1000_0000 + {27'd0, m_pc}});
            mq.push_back({m_pc + 5'd1, 32'h1000_0000 + {27'd0, 5'(m_pc + 5'd1)}});
            m_pc = m_pc + 5'd2;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      entry_t h;
      h = (mq.size() != 0) ? mq[0] : '0;
      chk("m_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      chk("m_ins", out_ins, h.ins);
      chk("m_pc", {27'd0, out_pc}, {27'd0, h.pc});
      chk("m_count", {29'd0, count}, 32'(mq.size()));
      chk("m_dir", {27'd0, dir}, {27'd0, m_pc});
      chk("m_dir2", {27'd0, dir2}, {27'd0, 5'(m_pc + 5'd1)});
   end

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   initial begin
      // Reset state, then fill and stall with decode not ready.
      nxt(); nxt();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_dir", {27'd0, dir}, 32'd0);
      chk("rst_dir2", {27'd0, dir2}, 32'd1);
      chk("rst_count", {29'd0, count}, 32'd0);
      rst = 1'b0;
      nxt();
      chk("fill_cnt1", {29'd0, count}, 32'd2);
      nxt();
      chk("fill_cnt2", {29'd0, count}, 32'd4);
      chk("fill_dir", {27'd0, dir}, 32'd4);
      chk("fill_dir2", {27'd0, dir2}, 32'd5);
      chk("fill_ins", out_ins, 32'h1000_0000);
      chk("fill_pc", {27'd0, out_pc}, 32'd0);
      nxt();
      chk("stall_dir", {27'd0, dir}, 32'd4);
      chk("stall_cnt", {29'd0, count}, 32'd4);

      // Redirect on a full queue with a simultaneous pop.
      redirect = 1'b1; redirect_pc = 5'd7; out_ready = 1'b1;
      nxt();
      chk("rd_valid", {31'd0, out_valid}, 32'd0);
      chk("rd_count", {29'd0, count}, 32'd0);
      chk("rd_dir", {27'd0, dir}, 32'd7);
      chk("rd_dir2", {27'd0, dir2}, 32'd8);
      redirect = 1'b0; out_ready = 1'b0;
      nxt();
      chk("rd_tgt_pc", {27'd0, out_pc}, 32'd7);
      chk("rd_tgt_ins", out_ins, 32'h1000_0007);

      // Wrap-around from PC 30.
      redirect = 1'b1; redirect_pc = 5'd30;
      nxt();
      redirect = 1'b0;
      nxt();
      chk("wrap_dir1", {27'd0, dir}, 32'd0);
      nxt();
      chk("wrap_dir2", {27'd0, dir}, 32'd2);
      chk("wrap_pc0", {27'd0, out_pc}, 32'd30);
      out_ready = 1'b1;
      nxt(); chk("wrap_pc1", {27'd0, out_pc}, 32'd31);
      nxt(); chk("wrap_pc2", {27'd0, out_pc}, 32'd0);
      nxt(); chk("wrap_pc3", {27'd0, out_pc}, 32'd1);

      // Streaming from reset with decode always ready.
      rst = 1'b1;
      nxt();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         nxt();
         chk("str_valid", {31'd0, out_valid}, 32'd1);
         chk("str_pc", {27'd0, out_pc}, 32'(i));
         chk("str_ins", out_ins, 32'h1000_0000 + 32'(i));
      end

      // Asynchronous reset between edges.
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", {31'd0, out_valid}, 32'd0);
      chk("ar_ins", out_ins, 32'd0);
      chk("ar_pc", {27'd0, out_pc}, 32'd0);
      chk("ar_dir", {27'd0, dir}, 32'd0);
      chk("ar_count", {29'd0, count}, 32'd0);
      nxt();
      rst = 1'b0;
      nxt();
      chk("ar_resume_pc", {27'd0, out_pc}, 32'd0);
      nxt(); nxt(); nxt();

      // Fetch disable with three entries queued.
      chk("dis_cnt3", {29'd0, count}, 32'd3);
      chk("dis_dir0", {27'd0, dir}, 32'd6);
      fetch_en = 1'b0;
      nxt();
      chk("dis_cnt2", {29'd0, count}, 32'd2);
      chk("dis_dir1", {27'd0, dir}, 32'd6);
      nxt();
      chk("dis_cnt1", {29'd0, count}, 32'd1);
      chk("dis_dir2", {27'd0, dir}, 32'd6);
      nxt();
      chk("dis_cnt0", {29'd0, count}, 32'd0);
      chk("dis_valid", {31'd0, out_valid}, 32'd0);
      chk("dis_dir3", {27'd0, dir}, 32'd6);
      nxt();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
